// File: rtl/croc_pkg.sv
// Shared constants for the crocodile motion scheduler: coordinate widths,
// default playfield geometry and the scheduler FSM encoding.
package croc_pkg;

  localparam int COORD_W = 10;
  localparam int STEP_W  = COORD_W + 1;

  localparam int DEF_Y_MIN      = 8;
  localparam int DEF_Y_MAX      = 330;
  localparam int DEF_CROC_W     = 50;
  localparam int DEF_CROC_H     = 150;
  localparam int DEF_BASE_SPEED = 4;
  localparam int DEF_V_TRIG     = 480;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UPDATE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Pixels per frame for a given speed level: base * (level + 1).
  function automatic logic [STEP_W-1:0] step_size(input int base, input logic [1:0] lvl);
    return STEP_W'(base) * ({{(STEP_W-2){1'b0}}, lvl} + STEP_W'(1));
  endfunction

endpackage

// File: rtl/croc_step.sv
// Combinational step engine: advances one crocodile by one frame step,
// clamping at the vertical limits and flipping direction on contact.
module croc_step
  import croc_pkg::*;
#(
  parameter int Y_MIN = DEF_Y_MIN,
  parameter int Y_MAX = DEF_Y_MAX
) (
  input  logic [COORD_W-1:0] y,
  input  logic               dir,
  input  logic [STEP_W-1:0]  step,
  output logic [COORD_W-1:0] y_next,
  output logic               dir_next
);

  logic [STEP_W-1:0] y_ext;
  logic [STEP_W-1:0] sum;
  logic [STEP_W-1:0] lim_lo;

  assign y_ext  = {1'b0, y};
  assign sum    = y_ext + step;
  assign lim_lo = STEP_W'(Y_MIN) + step;

  // Clamp instead of testing for exact equality so large steps never wrap.
  always_comb begin
    y_next   = y;
    dir_next = dir;
    if (dir) begin
      if (y_ext < lim_lo) begin
        y_next   = COORD_W'(Y_MIN);
        dir_next = 1'b0;
      end else begin
        y_next = COORD_W'(y_ext - step);
      end
    end else begin
      if (sum >= STEP_W'(Y_MAX)) begin
        y_next   = COORD_W'(Y_MAX);
        dir_next = 1'b1;
      end else begin
        y_next = sum[COORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/croc_motion_sched.sv
// Frame-synchronous crocodile scheduler: one shared step engine updates each
// crocodile during vertical blank. Define CROC_COLLIDE_EN for the collision flag.
module croc_motion_sched
  import croc_pkg::*;
#(
  parameter int N_CROC     = 4,
  parameter int Y_MIN      = DEF_Y_MIN,
  parameter int Y_MAX      = DEF_Y_MAX,
  parameter int Y_STAGGER  = 64,
  parameter int X_BASE     = 100,
  parameter int X_PITCH    = 120,
  parameter int CROC_W     = DEF_CROC_W,
  parameter int CROC_H     = DEF_CROC_H,
  parameter int BASE_SPEED = DEF_BASE_SPEED,
  parameter int V_TRIG     = DEF_V_TRIG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [COORD_W-1:0]        hc,
  input  logic [COORD_W-1:0]        vc,
  input  logic                      run,
  input  logic [1:0]                level,
  input  logic                      player_in,
  input  logic                      collide_clr,
  output logic [COORD_W*N_CROC-1:0] croc_y,
  output logic [N_CROC-1:0]         croc_dir,
  output logic                      croc_in,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      collide,
  output logic [1:0]                fsm_state
);

  localparam int IDX_W = (N_CROC > 1) ? $clog2(N_CROC) : 1;

  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic               trig;
  logic               trig_q;
  logic               start;
  logic [COORD_W-1:0] ypos [N_CROC];
  logic [N_CROC-1:0]  dir;
  logic [COORD_W-1:0] y_sel;
  logic [COORD_W-1:0] y_next;
  logic               dir_sel;
  logic               dir_next;
  logic [STEP_W-1:0]  step;
  logic [N_CROC-1:0]  hit;
  logic               croc_in_comb;

  assign trig  = (vc == COORD_W'(V_TRIG)) && (hc == '0);
  assign start = trig & ~trig_q;
  assign step  = step_size(BASE_SPEED, level);

  assign y_sel   = ypos[idx];
  assign dir_sel = dir[idx];

  croc_step #(
    .Y_MIN (Y_MIN),
    .Y_MAX (Y_MAX)
  ) u_step (
    .y        (y_sel),
    .dir      (dir_sel),
    .step     (step),
    .y_next   (y_next),
    .dir_next (dir_next)
  );

  // run only gates the start; a pass in flight always runs to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      trig_q <= 1'b0;
    end else begin
      trig_q <= trig;
      case (state)
        ST_IDLE: begin
          if (start && run) begin
            state <= ST_UPDATE;
            idx   <= '0;
          end
        end
        ST_UPDATE: begin
          if (idx == IDX_W'(N_CROC - 1)) state <= ST_DONE;
          else                           idx   <= idx + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CROC; i++) begin
        ypos[i] <= COORD_W'(Y_MIN + i * Y_STAGGER);
        dir[i]  <= ((i % 2) == 1);
      end
    end else if (state == ST_UPDATE) begin
      ypos[idx] <= y_next;
      dir[idx]  <= dir_next;
    end
  end

  // Inclusive rectangle test per crocodile, done in 11 bits to avoid overflow.
  for (genvar i = 0; i < N_CROC; i++) begin : g_cov
    localparam logic [STEP_W-1:0] X_LO = STEP_W'(X_BASE + i * X_PITCH);
    localparam logic [STEP_W-1:0] X_HI = STEP_W'(X_BASE + i * X_PITCH + CROC_W);
    logic [STEP_W-1:0] y_lo;
    logic [STEP_W-1:0] y_hi;
    assign y_lo   = {1'b0, ypos[i]};
    assign y_hi   = y_lo + STEP_W'(CROC_H);
    assign hit[i] = ({1'b0, hc} >= X_LO) && ({1'b0, hc} <= X_HI) &&
                    ({1'b0, vc} >= y_lo) && ({1'b0, vc} <= y_hi);
    assign croc_y[COORD_W*i +: COORD_W] = ypos[i];
  end

  assign croc_in_comb = |hit;

  always_ff @(posedge clk) begin
    if (rst) croc_in <= 1'b0;
    else     croc_in <= croc_in_comb;
  end

`ifdef CROC_COLLIDE_EN
  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst)                            collide <= 1'b0;
    else if (croc_in_comb && player_in) collide <= 1'b1;
    else if (collide_clr)               collide <= 1'b0;
  end
`else
  logic unused_collide_inputs;
  assign unused_collide_inputs = player_in ^ collide_clr;
  assign collide = 1'b0;
`endif

  assign croc_dir   = dir;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign fsm_state  = state;

endmodule

// File: doc/croc_motion_sched.md
Name: croc_motion_sched

Overview:
- Frame-synchronous scheduler that owns the vertical motion of N_CROC crocodile obstacles in the VGA game.
- Once per frame, during vertical blank, a single shared step engine updates each crocodile in turn: position, bounce direction and level-dependent speed.
- Registered pixel-coverage and player-collision outputs feed the colour mux and the game-state logic.

Parameters:
- N_CROC, 4, number of crocodiles (1..8).
- Y_MIN, 8, topmost legal crocodile Y.
- Y_MAX, 330, bottommost legal crocodile Y (480 - CROC_H).
- Y_STAGGER, 64, reset Y spacing between consecutive crocodiles.
- X_BASE, 100, X of crocodile 0.
- X_PITCH, 120, X spacing between crocodiles.
- CROC_W, 50, width offset; coverage is inclusive, X..X+CROC_W.
- CROC_H, 150, height offset; coverage is inclusive, Y..Y+CROC_H.
- BASE_SPEED, 4, pixels per frame at level 0.
- V_TRIG, 480, vc value that starts the update pass.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst  in  1  synchronous, active-high reset.
- hc  in  10  horizontal pixel counter.
- vc  in  10  vertical pixel counter.
- run  in  1  1 = motion enabled; 0 = frame ticks ignored.
- level  in  2  speed level; step = BASE_SPEED*(level+1).
- player_in  in  1  player sprite covers the current pixel (same alignment as hc/vc).
- collide_clr  in  1  clears the sticky collision flag.
- croc_y  out  10*N_CROC  packed Y positions; croc i occupies bits [10i+9:10i].
- croc_dir  out  N_CROC  1 = moving up, 0 = moving down.
- croc_in  out  1  some crocodile covers pixel (hc,vc); registered.
- busy  out  1  update pass in progress.
- frame_done  out  1  one-cycle pulse at the end of each update pass.
- collide  out  1  sticky player/crocodile overlap flag.

Behaviour:
- Reset values:
  - croc i Y = Y_MIN + i*Y_STAGGER; croc_dir[i] = i odd.
  - FSM IDLE; busy=0, frame_done=0, croc_in=0, collide=0.
- Trigger:
  - trig = (vc==V_TRIG && hc==0), registered as trig_q; start = trig & ~trig_q.
  - A pass starts only on start with run=1. Start in any state other than IDLE is ignored.
- FSM: IDLE -> UPDATE -> DONE -> IDLE.
  - Start seen in cycle t: UPDATE during cycles t+1 .. t+N_CROC, with idx = 0..N_CROC-1.
  - Croc idx is written at the edge closing its UPDATE cycle.
  - DONE occupies cycle t+N_CROC+1; frame_done=1 in that cycle only.
  - busy=1 while in UPDATE or DONE.
  - run is sampled only at start; dropping run mid-pass completes the pass.
- Step arithmetic: 11-bit unsigned, s = BASE_SPEED*(level+1).
  - Down: if Y+s >= Y_MAX then Y=Y_MAX, dir=up; else Y=Y+s.
  - Up: if Y < Y_MIN+s then Y=Y_MIN, dir=down; else Y=Y-s.
  - Clamping replaces exact-equality bounce, so no wrap-around is possible for any level.
  - level is sampled per step; a change mid-pass affects the remaining crocodiles only.
- Coverage:
  - Registered, 1-cycle latency.
  - croc_in = OR over i of (X_i <= hc <= X_i+CROC_W) && (Y_i <= vc <= Y_i+CROC_H), with X_i = X_BASE + i*X_PITCH.
  - Uses the current registered Y values.
- Reset mid-pass: reset returns all Y/dir values to reset values and the FSM to IDLE; no frame_done is emitted.

Optional Feature:
- Macro: CROC_COLLIDE_EN.
- Defined:
  - collide is set when croc_in_comb && player_in, where croc_in_comb is the unregistered coverage term of the same cycle.
  - Once set it holds until collide_clr or rst.
  - If set and clear occur in the same cycle, set wins.
- Undefined: collide is tied to 0 and player_in/collide_clr are unused.

Decomposition:
- Package croc_pkg:
  - coordinate width constant (10).
  - default geometry constants: Y_MIN, Y_MAX, CROC_W, CROC_H, BASE_SPEED, V_TRIG.
  - FSM state encoding: IDLE, UPDATE, DONE.
- Sub-module croc_step: purely combinational (Y, dir, s) -> (Y_next, dir_next) step engine, one instance shared across all crocodiles.
- Coverage compare is generated per crocodile inside the top module.

Test Plan:
- Reset: croc_y = {200,136,72,8} (croc3..croc0), croc_dir = 4'b1010, busy=0, collide=0.
- Pass at level 0:
  - Stimulus: run=1, hc=0, vc=480.
  - busy high for 5 cycles; frame_done pulses 5 cycles after start.
  - Y becomes {196,140,68,12}.
- Bounce:
  - croc0 at 328 moving down, s=4 -> 330, dir=up; next pass -> 326.
  - croc at 10 moving up -> 8, dir=down.
  - level=3 (s=16) from Y=320 moving down -> 330, no wrap.
- run=0: three trigger frames -> croc_y unchanged, busy never set, no frame_done.
- Coverage at reset positions:
  - hc=100, vc=8 -> croc_in=1 one cycle later.
  - hc=151, vc=8 -> 0.
  - hc=150, vc=158 -> 1.
  - hc=220, vc=71 -> 0.
- Collision and reset (CROC_COLLIDE_EN):
  - player_in=1 at hc=100, vc=8 -> collide=1 and stays 1 until collide_clr.
  - rst asserted during the second UPDATE cycle -> reset positions restored, no frame_done.
